mul_pipe: RTL and testbench

- Parametrised pipelined integer multiplier for the MDU. It covers MUL, MULH, MULHSU, MULHU and, when XLEN=64, MULW.
- Operands and opcode enter in the Execute stage. The XLEN-wide result leaves after STAGES clock edges with a matching valid bit.
- Pipeline stall and flush are honoured at every stage.
- It is the successor to the fixed two-stage partial-product multiplier: depth is configurable and half-select and word-op result formatting happen inside the block.

---
 rtl/mul_pipe.sv | 132 +++++++++++++
 tb/tb_mul_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined MUL/MULH/MULHSU/MULHU (+MULW at XLEN=64); result after STAGES edges.
// StallM freezes every stage; FlushM (wins over StallM) kills all in-flight ops and the one presented.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            ValidE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  input  logic            WE,
  output logic            ValidOut,
  output logic [XLEN-1:0] MulResult
);

  localparam int PW  = 2 * XLEN;
  localparam int H   = XLEN / 2;
  localparam int PPW = XLEN + 2;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("mul_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mul_pipe: STAGES must be in 1..4");
  end

  // Four addends whose modular sum is the low PW bits of the extended product.
  typedef struct packed {
    logic          vld;
    logic [2:0]    f3;
    logic          w;
    logic [PW-1:0] v0;
    logic [PW-1:0] v1;
    logic [PW-1:0] v2;
    logic [PW-1:0] v3;
  } stg_t;

  function automatic stg_t csa(input stg_t x);
    logic [PW-1:0] s1;
    logic [PW-1:0] c1;
    stg_t          y;
    y    = x;
    s1   = x.v0 ^ x.v1 ^ x.v2;
    c1   = ((x.v0 & x.v1) | (x.v0 & x.v2) | (x.v1 & x.v2)) << 1;
    y.v0 = s1 ^ c1 ^ x.v3;
    y.v1 = ((s1 & c1) | (s1 & x.v3) | (c1 & x.v3)) << 1;
    y.v2 = '0;
    y.v3 = '0;
    return y;
  endfunction

  function automatic logic [PW-1:0] total(input stg_t x);
    return x.v0 + x.v1 + x.v2 + x.v3;
  endfunction

  function automatic logic [XLEN-1:0] fmt(input logic [PW-1:0] p, input logic [2:0] f3,
                                          input logic w);
    if (f3 != 3'b000) return p[PW-1:XLEN];
    if (XLEN == 64 && w) return XLEN'($signed(p[31:0]));
    return p[XLEN-1:0];
  endfunction

  logic                  sa;
  logic                  sb;
  logic [XLEN:0]         ax;
  logic [XLEN:0]         bx;
  logic signed [H:0]     al;
  logic signed [H:0]     ah;
  logic signed [H:0]     bl;
  logic signed [H:0]     bh;
  logic signed [PPW-1:0] p_ll;
  logic signed [PPW-1:0] p_lh;
  logic signed [PPW-1:0] p_hl;
  logic signed [PPW-1:0] p_hh;
  stg_t                  in_s;

  // Low halves are always unsigned; the high halves carry the opcode's sign extension.
  always_comb begin
    sa        = (Funct3E == 3'b001) || (Funct3E == 3'b010);
    sb        = (Funct3E == 3'b001);
    ax        = {sa & ForwardedSrcAE[XLEN-1], ForwardedSrcAE};
    bx        = {sb & ForwardedSrcBE[XLEN-1], ForwardedSrcBE};
    al        = {1'b0, ax[H-1:0]};
    ah        = ax[XLEN:H];
    bl        = {1'b0, bx[H-1:0]};
    bh        = bx[XLEN:H];
    p_ll      = PPW'(al) * PPW'(bl);
    p_lh      = PPW'(al) * PPW'(bh);
    p_hl      = PPW'(ah) * PPW'(bl);
    p_hh      = PPW'(ah) * PPW'(bh);
    in_s.vld  = ValidE;
    in_s.f3   = Funct3E;
    in_s.w    = WE;
    in_s.v0   = PW'(p_ll);
    in_s.v1   = PW'(p_lh) << H;
    in_s.v2   = PW'(p_hl) << H;
    in_s.v3   = PW'(p_hh) << XLEN;
  end

  if (STAGES == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (reset || FlushM) begin
        ValidOut  <= 1'b0;
        MulResult <= '0;
      end else if (!StallM) begin
        ValidOut  <= in_s.vld;
        MulResult <= fmt(total(in_s), in_s.f3, in_s.w);
      end
    end
  end else begin : g_multi
    stg_t st [STAGES-1];

    // st[0] holds partial products; later entries hold the carry-save pair.
    always_ff @(posedge clk) begin
      if (reset || FlushM) begin
        for (int i = 0; i < STAGES - 1; i++) st[i] <= '0;
        ValidOut  <= 1'b0;
        MulResult <= '0;
      end else if (!StallM) begin
        st[0] <= in_s;
        for (int i = 1; i < STAGES - 1; i++) st[i] <= csa(st[i-1]);
        ValidOut  <= st[STAGES-2].vld;
        MulResult <= fmt(total(st[STAGES-2]), st[STAGES-2].f3, st[STAGES-2].w);
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed-vector bench for mul_pipe across XLEN/STAGES variants sharing one stimulus bus.
module tb_mul_pipe;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        vld;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  f3;
  logic        we;

  logic        a_vld, w_vld, b_vld, r_vld, o_vld;
  logic [31:0] a_res, b_res, r_res, o_res;
  logic [63:0] w_res;

  int n_vec = 0;
  int n_err = 0;

  mul_pipe #(.XLEN(32), .STAGES(2)) u_a (
    .clk(clk), .reset(reset), .StallM(stall), .FlushM(flush), .ValidE(vld),
    .ForwardedSrcAE(a[31:0]), .ForwardedSrcBE(b[31:0]), .Funct3E(f3), .WE(we),
    .ValidOut(a_vld), .MulResult(a_res));

  mul_pipe #(.XLEN(64), .STAGES(2)) u_w (
    .clk(clk), .reset(reset), .StallM(stall), .FlushM(flush), .ValidE(vld),
    .ForwardedSrcAE(a), .ForwardedSrcBE(b), .Funct3E(f3), .WE(we),
    .ValidOut(w_vld), .MulResult(w_res));

  mul_pipe #(.XLEN(32), .STAGES(3)) u_b (
    .clk(clk), .reset(reset), .StallM(stall), .FlushM(flush), .ValidE(vld),
    .ForwardedSrcAE(a[31:0]), .ForwardedSrcBE(b[31:0]), .Funct3E(f3), .WE(we),
    .ValidOut(b_vld), .MulResult(b_res));

  mul_pipe #(.XLEN(32), .STAGES(4)) u_r (
    .clk(clk), .reset(reset), .StallM(stall), .FlushM(flush), .ValidE(vld),
    .ForwardedSrcAE(a[31:0]), .ForwardedSrcBE(b[31:0]), .Funct3E(f3), .WE(we),
    .ValidOut(r_vld), .MulResult(r_res));

  mul_pipe #(.XLEN(32), .STAGES(1)) u_o (
    .clk(clk), .reset(reset), .StallM(stall), .FlushM(flush), .ValidE(vld),
    .ForwardedSrcAE(a[31:0]), .ForwardedSrcBE(b[31:0]), .Funct3E(f3), .WE(we),
    .ValidOut(o_vld), .MulResult(o_res));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One op through the 1- and 2-stage XLEN=32 pipes, checking the exact edge it appears on.
  task automatic run32(input string tag, input logic [2:0] op, input logic w,
                       input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
    vld = 1'b1; a = {32'h0, av}; b = {32'h0, bv}; f3 = op; we = w;
    @(negedge clk);
    vld = 1'b0;
    check({tag, ".s1.v"}, {63'h0, o_vld}, 64'h1);
    check({tag, ".s1.r"}, {32'h0, o_res}, {32'h0, exp});
    check({tag, ".s2.early"}, {63'h0, a_vld}, 64'h0);
    @(negedge clk);
    check({tag, ".s1.bubble"}, {63'h0, o_vld}, 64'h0);
    check({tag, ".s2.v"}, {63'h0, a_vld}, 64'h1);
    check({tag, ".s2.r"}, {32'h0, a_res}, {32'h0, exp});
  endtask

  task automatic run64(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] av, input logic [63:0] bv, input logic [63:0] exp);
    vld = 1'b1; a = av; b = bv; f3 = op; we = w;
    @(negedge clk);
    vld = 1'b0;
    check({tag, ".early"}, {63'h0, w_vld}, 64'h0);
    @(negedge clk);
    check({tag, ".v"}, {63'h0, w_vld}, 64'h1);
    check({tag, ".r"}, w_res, exp);
  endtask

  // One cycle of MUL stimulus on the 3-stage pipe; result checked when valid or when cr=1.
  task automatic step(input string tag, input logic v, input logic [31:0] av,
                      input logic [31:0] bv, input logic s, input logic fl,
                      input logic ev, input logic [31:0] er, input logic cr);
    vld = v; a = {32'h0, av}; b = {32'h0, bv}; f3 = 3'b000; we = 1'b0;
    stall = s; flush = fl;
    @(negedge clk);
    check({tag, ".v"}, {63'h0, b_vld}, {63'h0, ev});
    if (ev || cr) check({tag, ".r"}, {32'h0, b_res}, {32'h0, er});
  endtask

  logic r_exp_v [8];

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; vld = 1'b0;
    a = '0; b = '0; f3 = 3'b000; we = 1'b0;
    @(negedge clk);
    vld = 1'b1; a = 64'h5; b = 64'h7;
    @(negedge clk);
    check("rst.a.v", {63'h0, a_vld}, 64'h0);
    check("rst.a.r", {32'h0, a_res}, 64'h0);
    check("rst.w.v", {63'h0, w_vld}, 64'h0);
    check("rst.w.r", w_res, 64'h0);
    check("rst.b.v", {63'h0, b_vld}, 64'h0);
    check("rst.r.r", {32'h0, r_res}, 64'h0);
    check("rst.o.v", {63'h0, o_vld}, 64'h0);
    check("rst.o.r", {32'h0, o_res}, 64'h0);
    vld = 1'b0; reset = 1'b0;
    idle(5);

    run32("mulh.m1",    3'b001, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run32("mulhu.m1",   3'b011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run32("mulhsu.m1",  3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run32("mul.m1",     3'b000, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run32("mul.min2",   3'b000, 1'b0, 32'h80000000, 32'h00000002, 32'h00000000);
    run32("mulh.min",   3'b001, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000);
    run32("mulhsu.min", 3'b010, 1'b0, 32'h80000000, 32'h80000000, 32'hC0000000);
    run32("mulhu.min",  3'b011, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000);
    run32("mul.w32",    3'b000, 1'b1, 32'h12345678, 32'h00000010, 32'h23456780);

    run64("mulw",       3'b000, 1'b1, 64'h000000007FFFFFFF, 64'h2, 64'hFFFFFFFFFFFFFFFE);
    run64("mul64",      3'b000, 1'b0, 64'h000000007FFFFFFF, 64'h2, 64'h00000000FFFFFFFE);
    run64("mulhu64.w",  3'b011, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h0000000000000001);
    run64("mulh64.w",   3'b001, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    run64("mulhsu64",   3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'hFFFFFFFFFFFFFFFF);
    idle(4);

    step("bb0", 1, 3,  5,  0, 0, 0, 0,   0);
    step("bb1", 1, 7,  11, 0, 0, 0, 0,   0);
    step("bb2", 1, 13, 17, 0, 0, 1, 15,  0);
    step("bb3", 1, 19, 23, 0, 0, 1, 77,  0);
    step("bb4", 0, 0,  0,  0, 0, 1, 221, 0);
    step("bb5", 0, 0,  0,  0, 0, 1, 437, 0);
    step("bb6", 0, 0,  0,  0, 0, 0, 0,   0);
    idle(4);

    step("st0", 1, 3,  5,  0, 0, 0, 0,   0);
    step("st1", 1, 7,  11, 0, 0, 0, 0,   0);
    step("st2", 1, 13, 17, 0, 0, 1, 15,  0);
    step("st3", 1, 19, 23, 1, 0, 1, 15,  0);
    step("st4", 1, 19, 23, 1, 0, 1, 15,  0);
    step("st5", 1, 19, 23, 0, 0, 1, 77,  0);
    step("st6", 0, 0,  0,  0, 0, 1, 221, 0);
    step("st7", 0, 0,  0,  0, 0, 1, 437, 0);
    step("st8", 0, 0,  0,  0, 0, 0, 0,   0);
    idle(4);

    step("fl0", 1, 2,   3,   0, 0, 0, 0,  0);
    step("fl1", 1, 4,   5,   0, 0, 0, 0,  0);
    step("fl2", 1, 100, 100, 0, 1, 0, 0,  1);
    step("fl3", 1, 6,   7,   0, 0, 0, 0,  1);
    step("fl4", 0, 0,   0,   0, 0, 0, 0,  1);
    step("fl5", 0, 0,   0,   0, 0, 1, 42, 0);
    step("fl6", 0, 0,   0,   0, 0, 0, 0,  0);
    idle(4);

    step("fs0", 1, 2, 3, 0, 0, 0, 0, 0);
    step("fs1", 1, 4, 5, 0, 0, 0, 0, 0);
    step("fs2", 1, 8, 8, 1, 1, 0, 0, 1);
    step("fs3", 0, 0, 0, 0, 0, 0, 0, 0);
    step("fs4", 0, 0, 0, 0, 0, 0, 0, 0);
    step("fs5", 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b0; flush = 1'b0;
    idle(5);

    // Two ops into the 4-stage pipe, reset, then a fresh op on the first edge after reset.
    vld = 1'b1; a = 64'd10; b = 64'd10; f3 = 3'b000;
    @(negedge clk);
    a = 64'd12; b = 64'd12;
    @(negedge clk);
    reset = 1'b1; vld = 1'b0;
    @(negedge clk);
    check("rr.v", {63'h0, r_vld}, 64'h0);
    check("rr.r", {32'h0, r_res}, 64'h0);
    reset = 1'b0; vld = 1'b1; a = 64'd9; b = 64'd9;
    r_exp_v = '{0, 0, 0, 1, 0, 0, 0, 0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vld = 1'b0;
      check($sformatf("rr.post%0d.v", c), {63'h0, r_vld}, {63'h0, r_exp_v[c]});
      if (r_exp_v[c]) check("rr.new.r", {32'h0, r_res}, 64'd81);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
